fpu_issue_ctrl: RTL
===================

Name: fpu_issue_ctrl

Overview:
- Sequencer between the core's F-extension decode/issue stage and the FPU_S single-precision datapath.
- Accepts one FP operation at a time over a valid/ready handshake, resolves the rounding mode (static or dynamic from fcsr.frm), and holds operands stable for the FPU.
- Pulses the FPU start, waits out a minimum latency plus the FPU busy flag, then captures result and exception flags.
- Returns result and flags to writeback and emits a one-shot sticky-flag update for fcsr.fflags.

Parameters:
- MIN_LAT, 1: cycles after the start pulse before the result may be sampled; must be >= 1.
- CNT_W, 4: latency counter width; must hold MIN_LAT.

Ports:
- clk  in  1  system clock, rising edge
- rstLow  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous pipeline kill
- req_valid_i  in  1  operation request valid
- req_ready_o  out  1  request accepted when valid & ready
- req_rs1_i / req_rs2_i / req_rs3_i  in  32 each  operands
- req_funct5_i  in  5  FPU operation selector
- req_rm_i  in  3  instruction rm field
- req_rd_i  in  5  destination tag
- fcsr_frm_i  in  3  dynamic rounding mode from fcsr
- fpu_rs1_o / fpu_rs2_o / fpu_rs3_o  out  32 each  registered operands to FPU_S
- fpu_funct5_o  out  5  registered operation selector
- fpu_frm_o  out  3  resolved rounding mode
- fpu_start_o  out  1  one-cycle start pulse
- fpu_res_i  in  32  FPU result
- fpu_fflags_i  in  5  FPU flags {NV,DZ,OF,UF,NX}
- fpu_busy_i  in  1  FPU multi-cycle operation ongoing
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  writeback accepts response
- rsp_data_o  out  32  captured result
- rsp_rd_o  out  5  destination tag
- rsp_illegal_o  out  1  illegal rounding mode; no FPU operation was performed
- fflags_set_valid_o  out  1  one-cycle pulse, on the response handshake only
- fflags_set_o  out  5  flags to OR into fcsr.fflags; 0 when fflags_set_valid_o is low

Behaviour:
- Reset (rstLow=0, asynchronous):
  - State returns to IDLE.
  - All registered outputs go to 0: operands, funct5, frm, start, rsp_*, fflags_*.
  - req_ready_o is 0 while reset is asserted.
- req_ready_o = (state==IDLE) & !flush_i & rstLow. It is combinational and has no dependency on req_valid_i.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, on request acceptance:
  - Latch operands, funct5, rd, and the resolved rm.
  - rm 000..100: used as-is.
  - rm 111: fcsr_frm_i sampled in the acceptance cycle.
  - rm 101/110, or rm 111 with fcsr_frm_i in {101,110,111}: illegal. Set rsp_illegal, rsp_data=0, flags=0, go to RESP, never pulse start.
  - Legal rm: go to ISSUE.
- ISSUE:
  - fpu_start_o=1 for exactly this cycle.
  - Load counter with MIN_LAT; go to WAIT.
- WAIT:
  - Counter decrements each cycle until 0.
  - In a cycle with counter==0 and fpu_busy_i==0: capture fpu_res_i and fpu_fflags_i, go to RESP.
  - fpu_busy_i high at counter 0: remain in WAIT indefinitely.
- Operand outputs stay stable from ISSUE until leaving WAIT; they are not cleared afterwards.
- RESP:
  - rsp_valid_o=1; rsp_data/rd/illegal held stable until rsp_ready_i.
  - On the handshake cycle, fflags_set_valid_o=1 with fflags_set_o equal to the captured flags (pulse also fires for illegal responses, flags 0); go to IDLE.
- Latency, legal op, rsp_ready_i tied high:
  - Acceptance at cycle 0, start at cycle 1.
  - Capture at cycle 1+MIN_LAT (FPU not busy); rsp_valid_o from cycle 2+MIN_LAT.
  - Next request may be accepted one cycle after the handshake; no overlap.
- flush_i in any state:
  - Next state is IDLE; no request accepted that cycle.
  - A pending response is dropped and no fflags pulse occurs.
  - fpu_start_o forced 0 that cycle.
  - An in-flight FPU operation is abandoned; its result is never sampled.
- flush_i and rsp_ready_i high together in RESP: flush wins, no fflags pulse.

Decomposition:
- Shared defines header holds:
  - FSM state encodings.
  - Rounding-mode constants RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111.
  - fflags bit indices (NV=4, DZ=3, OF=2, UF=1, NX=0).
  - The 7FC00000 canonical NaN constant.
- One combinational sub-module, fpu_rm_resolve (inputs rm, frm; outputs resolved rm, illegal), reused by the decoder.

Test Plan:
- FPU_S attached, FADD 3F800000+40000000, rm 000, rsp_ready=1 -> start at cycle 1; rsp_valid at cycle 3; rsp_data 40400000; fflags_set_valid pulse with 00000.
- FSUB 7F800000-7F800000 -> rsp_data 7FC00000; fflags_set_o 10000 pulsed exactly once, on the handshake.
- rm 111, fcsr_frm 010 -> fpu_frm_o 010. Then rm 111 with fcsr_frm 101, and rm 110 -> rsp_illegal 1, rsp_data 0, fpu_start never asserted.
- Stub FPU, MIN_LAT=2, busy high for 4 cycles after start -> capture in first cycle busy low (cycle 5); operands stable throughout; req_ready 0 until handshake.
- rsp_ready held low 5 cycles -> rsp_valid/data/rd stable; req_ready 0; single fflags pulse on the cycle rsp_ready rises.
- Flush asserted in WAIT -> IDLE next cycle, no rsp_valid, no fflags pulse. Separately, rstLow dropped mid-RESP -> all outputs 0 immediately (asynchronous), next request accepted after release.

Source files
------------

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared encodings for the FPU issue sequencer: FSM states, rounding modes,
// fflags bit positions and the captured-response record.
package fpu_issue_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   localparam int FF_NV = 4;
   localparam int FF_DZ = 3;
   localparam int FF_OF = 2;
   localparam int FF_UF = 1;
   localparam int FF_NX = 0;

   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        illegal;
      logic [4:0]  flags;
   } rsp_t;

   function automatic logic rm_is_static(input logic [2:0] rm);
      case (rm)
         RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM: rm_is_static = 1'b1;
         default:                                rm_is_static = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// Rounding-mode resolution: DYN selects fcsr.frm; anything that does not end
// up as one of the five static modes is reported illegal.
module fpu_rm_resolve
   import fpu_issue_ctrl_pkg::*;
(
   input  logic [2:0] rm_i,
   input  logic [2:0] frm_i,
   output logic [2:0] rm_o,
   output logic       illegal_o
);

   always_comb begin
      rm_o      = (rm_i == RM_DYN) ? frm_i : rm_i;
      illegal_o = !rm_is_static(rm_o);
   end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer between F-extension decode and the FPU_S datapath:
// one operation in flight, latency timer plus busy wait, one-shot fflags update.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_ISSUE | operands held, start pulse to the FPU
// ST_WAIT  | latency down-counter, then wait for busy to drop
// ST_RESP  | response presented to writeback until accepted
module fpu_issue_ctrl
   import fpu_issue_ctrl_pkg::*;
#(
   parameter int MIN_LAT = 1,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rstLow,
   input  logic        flush_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_rs1_i,
   input  logic [31:0] req_rs2_i,
   input  logic [31:0] req_rs3_i,
   input  logic [4:0]  req_funct5_i,
   input  logic [2:0]  req_rm_i,
   input  logic [4:0]  req_rd_i,
   input  logic [2:0]  fcsr_frm_i,
   output logic [31:0] fpu_rs1_o,
   output logic [31:0] fpu_rs2_o,
   output logic [31:0] fpu_rs3_o,
   output logic [4:0]  fpu_funct5_o,
   output logic [2:0]  fpu_frm_o,
   output logic        fpu_start_o,
   input  logic [31:0] fpu_res_i,
   input  logic [4:0]  fpu_fflags_i,
   input  logic        fpu_busy_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic [4:0]  rsp_rd_o,
   output logic        rsp_illegal_o,
   output logic        fflags_set_valid_o,
   output logic [4:0]  fflags_set_o
);

   logic [1:0]       state_q, state_d;
   logic [31:0]      rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
   logic [4:0]       funct5_q, funct5_d;
   logic [2:0]       frm_q, frm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   rsp_t             rsp_q, rsp_d;

   logic       accept;
   logic [2:0] rm_res;
   logic       rm_illegal;

   fpu_rm_resolve u_rm_resolve (
      .rm_i      (req_rm_i),
      .frm_i     (fcsr_frm_i),
      .rm_o      (rm_res),
      .illegal_o (rm_illegal)
   );

   assign req_ready_o = (state_q == ST_IDLE) & !flush_i & rstLow;
   assign accept      = req_valid_i & req_ready_o;

   always_comb begin
      state_d  = state_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      rs3_d    = rs3_q;
      funct5_d = funct5_q;
      frm_d    = frm_q;
      cnt_d    = cnt_q;
      rsp_d    = rsp_q;
      // A flush abandons whatever is in flight; nothing is captured that cycle.
      if (flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  rs1_d         = req_rs1_i;
                  rs2_d         = req_rs2_i;
                  rs3_d         = req_rs3_i;
                  funct5_d      = req_funct5_i;
                  frm_d         = rm_res;
                  rsp_d.data    = '0;
                  rsp_d.rd      = req_rd_i;
                  rsp_d.illegal = rm_illegal;
                  rsp_d.flags   = '0;
                  state_d       = rm_illegal ? ST_RESP : ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // WAIT is entered one cycle after start, so it holds MIN_LAT-1.
               cnt_d   = CNT_W'(MIN_LAT - 1);
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (!fpu_busy_i) begin
                  rsp_d.data  = fpu_res_i;
                  rsp_d.flags = fpu_fflags_i;
                  state_d     = ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstLow) begin
      if (!rstLow) begin
         state_q  <= ST_IDLE;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rs3_q    <= '0;
         funct5_q <= '0;
         frm_q    <= '0;
         cnt_q    <= '0;
         rsp_q    <= '0;
      end else begin
         state_q  <= state_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rs3_q    <= rs3_d;
         funct5_q <= funct5_d;
         frm_q    <= frm_d;
         cnt_q    <= cnt_d;
         rsp_q    <= rsp_d;
      end
   end

   assign fpu_rs1_o    = rs1_q;
   assign fpu_rs2_o    = rs2_q;
   assign fpu_rs3_o    = rs3_q;
   assign fpu_funct5_o = funct5_q;
   assign fpu_frm_o    = frm_q;
   assign fpu_start_o  = (state_q == ST_ISSUE) & !flush_i;

   assign rsp_valid_o   = (state_q == ST_RESP) & !flush_i;
   assign rsp_data_o    = rsp_q.data;
   assign rsp_rd_o      = rsp_q.rd;
   assign rsp_illegal_o = rsp_q.illegal;

   assign fflags_set_valid_o = rsp_valid_o & rsp_ready_i;
   assign fflags_set_o       = fflags_set_valid_o ? rsp_q.flags : 5'b0;

endmodule
